stream_demux: RTL and testbench

- 1-to-2 demultiplexer for 64-bit datapath transfers. It is the steering counterpart of the 2:1 operand/result select.
- One input stream (valid/ready) is routed by a per-beat select bit into one of two output streams.
- Each output has its own small FIFO, so a stalled consumer does not block traffic bound for the other output once the head beat is steered.
- Used between the execute/writeback stage and the two downstream sinks (register-file writeback vs. memory/store path).

---
 rtl/stream_demux_if.sv | 35 +++
 rtl/stream_demux.sv | 72 +++++++
 tb/tb_stream_demux.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream, two output
// streams and the per-output occupancy counts.
interface stream_demux_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;

  // Producer/consumer side (drives the input beat and the output readies).
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, count0, count1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, count0, count1
  );
endinterface

// File: rtl/stream_demux.sv
// 1-to-2 stream demultiplexer: each input beat is steered by in_sel into one of
// two independent FIFOs, so a stalled sink only blocks beats addressed to it.
module stream_demux #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             w_in_ready;
  logic             w_push      [2];
  logic             w_pop       [2];
  logic             w_full      [2];
  logic             w_out_ready [2];
  logic [CW-1:0]    w_count     [2];
  logic [WIDTH-1:0] w_head      [2];

  // Ready looks only at the targeted FIFO's registered occupancy; a same-cycle
  // pop of a full FIFO does not open it up.
  assign w_in_ready     = !w_full[bus.in_sel];
  assign w_out_ready[0] = bus.out0_ready;
  assign w_out_ready[1] = bus.out1_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign w_push[gi]  = bus.in_valid && w_in_ready && (bus.in_sel == 1'(gi));
    assign w_pop[gi]   = (r_count != '0) && w_out_ready[gi];
    assign w_full[gi]  = (r_count == CW'(DEPTH));
    assign w_count[gi] = r_count;
    assign w_head[gi]  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= bus.in_data;
          r_wr_ptr        <= r_wr_ptr + PW'(1);
        end
        if (w_pop[gi]) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out0_valid = (w_count[0] != '0);
  assign bus.out1_valid = (w_count[1] != '0);
  assign bus.out0_data  = w_head[0];
  assign bus.out1_data  = w_head[1];
  assign bus.count0     = w_count[0];
  assign bus.count1     = w_count[1];
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a table of per-cycle input records with the expected
// in_ready, plus per-output scoreboard queues that predict valid/data/count.
module tb_stream_demux;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] sb0[$];
  logic [WIDTH-1:0] sb1[$];

  typedef struct {
    logic             v;
    logic             sel;
    logic [WIDTH-1:0] data;
    logic             r0;
    logic             r1;
    logic             exp_rdy;
  } vec_t;

  vec_t tbl[$];

  stream_demux_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stream_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1, input logic exp_rdy);
    vec_t e;
    e.v = v; e.sel = sel; e.data = d; e.r0 = r0; e.r1 = r1; e.exp_rdy = exp_rdy;
    tbl.push_back(e);
  endtask

  // One clock cycle: drive after the falling edge, check before the rising
  // edge, then retire/accept beats in the scoreboard at the rising edge.
  task automatic cycle(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1, input logic exp_rdy);
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    if (v) check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out0_valid", 64'(bus.out0_valid), 64'(sb0.size() != 0));
    check("count0", 64'(bus.count0), 64'(sb0.size()));
    if (sb0.size() != 0) check("out0_data", bus.out0_data, sb0[0]);
    check("out1_valid", 64'(bus.out1_valid), 64'(sb1.size() != 0));
    check("count1", 64'(bus.count1), 64'(sb1.size()));
    if (sb1.size() != 0) check("out1_data", bus.out1_data, sb1[0]);
    @(posedge clk);
    if (r0 && sb0.size() != 0) $display("pop  out0 data=%h", sb0.pop_front());
    if (r1 && sb1.size() != 0) $display("pop  out1 data=%h", sb1.pop_front());
    if (v && exp_rdy) begin
      if (sel) sb1.push_back(d);
      else     sb0.push_back(d);
      $display("push out%0d data=%h", sel, d);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out0_valid"}, 64'(bus.out0_valid), 64'(0));
    check({tag, "_out1_valid"}, 64'(bus.out1_valid), 64'(0));
    check({tag, "_count0"}, 64'(bus.count0), 64'(0));
    check({tag, "_count1"}, 64'(bus.count1), 64'(0));
    check({tag, "_out0_data"}, bus.out0_data, 64'(0));
    check({tag, "_out1_data"}, bus.out1_data, 64'(0));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;

    // Head-of-line stall on full out0, then re-steer to out1; drain.
    add(1, 0, 64'h10, 0, 0, 1);
    add(1, 0, 64'h11, 0, 0, 1);
    add(1, 0, 64'h12, 0, 0, 0);
    add(1, 1, 64'h12, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 64'h0, 1, 1, 0);
    // Continuous streaming to out0, pointers wrap several times.
    for (int i = 0; i < 8; i++) add(1, 0, 64'(i), 1, 0, 1);
    add(0, 0, 64'h0, 1, 0, 0);
    // Alternating destinations with both sinks ready.
    for (int i = 0; i < 4; i++) add(1, 1'(i), 64'hA0 + 64'(i), 1, 1, 1);
    add(0, 0, 64'h0, 1, 1, 0);
    // Full out1 does not block out0; no pass-through while out1 pops.
    add(1, 1, 64'hB0, 0, 0, 1);
    add(1, 1, 64'hB1, 0, 0, 1);
    add(1, 0, 64'hB2, 0, 0, 1);
    add(1, 1, 64'hB3, 0, 0, 0);
    add(1, 1, 64'hB3, 0, 1, 0);
    add(1, 1, 64'hB3, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 64'h0, 1, 1, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("rst");
    check("rst_in_ready_sel0", 64'(bus.in_ready), 64'(1));
    bus.in_sel = 1'b1;
    #1;
    check("rst_in_ready_sel1", 64'(bus.in_ready), 64'(1));

    // Single beat to out1 held for several cycles, then popped.
    cycle(1, 1, 64'hDEAD_BEEF_0000_0001, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 64'h0, 0, 0, 0);
    cycle(0, 0, 64'h0, 0, 1, 0);
    cycle(0, 0, 64'h0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].r0, tbl[i].r1, tbl[i].exp_rdy);
    end

    // Asynchronous reset mid-transfer, pulsed between clock edges.
    cycle(1, 0, 64'hE0, 0, 0, 1);
    cycle(1, 0, 64'hE1, 0, 0, 1);
    cycle(1, 1, 64'hE2, 0, 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    #1;
    check("pre_rst_count0", 64'(bus.count0), 64'(2));
    check("pre_rst_count1", 64'(bus.count1), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    #1;
    rst_n = 1'b1;
    sb0.delete();
    sb1.delete();
    cycle(1, 0, 64'h55, 0, 0, 1);
    cycle(0, 0, 64'h0, 0, 0, 0);
    check("post_rst_count0", 64'(bus.count0), 64'(1));
    check("post_rst_out0_data", bus.out0_data, 64'h55);
    cycle(0, 0, 64'h0, 1, 0, 0);
    cycle(0, 0, 64'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
